// File: rtl/fcore_sequencer.sv
// fcore_sequencer: fCore control unit. Walks the program held in instruction memory and issues
// one instruction beat per time-multiplexed channel towards the decoder on an AXI-stream with
// backpressure. Handles LDC constant loads, EFI calls, program-counter overrun faults and the
// DMA/decoder gating.
//
// Optional feature: define FCORE_SEQUENCER_EFI_TIMEOUT_EN to fault (cause 2'b10) when efi_done
// does not arrive within EFI_TIMEOUT cycles. Without it EFI_WAIT waits indefinitely.
//
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   run / core_stop / fault_clear   start (IDLE only) / end of program / leave FAULT
//   program_size, n_channels     number of valid program words, active channel count
//   wide_instruction_in          {mem[pc+1], mem[pc]}, valid one cycle after program_counter moves
//   efi_done / efi_start         EFI completion in / one-cycle EFI launch pulse out
//   program_counter              instruction-memory address
//   load_data                    LDC constant
//   decoder_enable, dma_enable   high while sequencing / high while idle
//   done                         one-cycle pulse on stop
//   fault, fault_cause           sticky fault flag; 01 = PC overrun, 10 = EFI timeout
//   instruction_stream_*         AXI-stream master: data = instruction, dest = channel, user = pc
module fcore_sequencer #(
  parameter int unsigned PC_WIDTH          = 12,
  parameter int unsigned OPCODE_WIDTH      = 5,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned MAX_CHANNELS      = 255,
  parameter int unsigned EFI_IMPLEMENTED   = 0,
  parameter int unsigned EFI_TIMEOUT       = 1024,
  parameter int unsigned LDC_OPCODE        = 6,
  parameter int unsigned EFI_OPCODE        = 14,
  // Derived; do not override.
  parameter int unsigned CH_W              = $clog2(MAX_CHANNELS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           core_stop,
  input  logic                           fault_clear,
  input  logic [15:0]                    program_size,
  input  logic [CH_W-1:0]                n_channels,
  input  logic [2*INSTRUCTION_WIDTH-1:0] wide_instruction_in,
  input  logic                           efi_done,
  output logic [PC_WIDTH-1:0]            program_counter,
  output logic [INSTRUCTION_WIDTH-1:0]   load_data,
  output logic                           efi_start,
  output logic                           decoder_enable,
  output logic                           dma_enable,
  output logic                           done,
  output logic                           fault,
  output logic [1:0]                     fault_cause,
  output logic [INSTRUCTION_WIDTH-1:0]   instruction_stream_data,
  output logic [CH_W-1:0]                instruction_stream_dest,
  output logic [PC_WIDTH-1:0]            instruction_stream_user,
  output logic                           instruction_stream_valid,
  input  logic                           instruction_stream_ready
);

  typedef enum logic [2:0] {StIdle, StFetch, StRun, StEfiWait, StFault} state_e;

  state_e                         state_q, state_d;
  logic [PC_WIDTH-1:0]            pc_q, pc_d;
  logic [CH_W-1:0]                ch_q, ch_d;
  logic [INSTRUCTION_WIDTH-1:0]   load_data_q, load_data_d;
  logic                           ldc_q, ldc_d;
  logic [INSTRUCTION_WIDTH-1:0]   ldc_instr_q, ldc_instr_d;
  logic                           valid_q, valid_d;
  logic [INSTRUCTION_WIDTH-1:0]   data_q, data_d;
  logic [CH_W-1:0]                dest_q, dest_d;
  logic [PC_WIDTH-1:0]            user_q, user_d;
  logic                           efi_start_q, efi_start_d;
  logic                           done_q, done_d;
  logic [1:0]                     cause_q, cause_d;

  logic [INSTRUCTION_WIDTH-1:0]   instr_lo, instr_hi, beat_instr;
  logic                           ch_first, ch_last, is_ldc, ldc_now, is_efi;
  logic                           can_issue, overrun, efi_timeout_hit;
  logic                           advance, adv_ldc;

  assign instr_lo  = wide_instruction_in[INSTRUCTION_WIDTH-1:0];
  assign instr_hi  = wide_instruction_in[2*INSTRUCTION_WIDTH-1:INSTRUCTION_WIDTH];
  assign ch_first  = (ch_q == '0);
  assign ch_last   = (ch_q == n_channels - CH_W'(1));
  // Channels after the first replay the LDC word latched on channel 0.
  assign beat_instr = (!ch_first && ldc_q) ? ldc_instr_q : instr_lo;
  assign is_ldc    = (instr_lo[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(LDC_OPCODE));
  // On channel 0 the LDC decision is being made this cycle, so use it directly.
  assign ldc_now   = ch_first ? is_ldc : ldc_q;
  assign is_efi    = (EFI_IMPLEMENTED != 0) &&
                     (beat_instr[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(EFI_OPCODE));
  assign can_issue = !valid_q || instruction_stream_ready;
  assign overrun   = (32'(pc_q) >= 32'(program_size));

`ifdef FCORE_SEQUENCER_EFI_TIMEOUT_EN
  logic [15:0] efi_cnt_q, efi_cnt_d;
  assign efi_timeout_hit = (efi_cnt_q == 16'(EFI_TIMEOUT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      efi_cnt_q <= '0;
    end else begin
      efi_cnt_q <= efi_cnt_d;
    end
  end
`else
  assign efi_timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ch_d        = ch_q;
    load_data_d = load_data_q;
    ldc_d       = ldc_q;
    ldc_instr_d = ldc_instr_q;
    // An outstanding beat stays valid until accepted, whatever the state.
    valid_d     = valid_q & ~instruction_stream_ready;
    data_d      = data_q;
    dest_d      = dest_q;
    user_d      = user_q;
    efi_start_d = 1'b0;
    done_d      = 1'b0;
    cause_d     = cause_q;
    advance     = 1'b0;
    adv_ldc     = 1'b0;
`ifdef FCORE_SEQUENCER_EFI_TIMEOUT_EN
    efi_cnt_d   = efi_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        pc_d = '0;
        ch_d = '0;
        if (run && (n_channels != '0) && (program_size != '0)) begin
          state_d = StFetch;
        end
      end

      StFetch: begin
        if (core_stop) begin
          done_d  = 1'b1;
          state_d = StIdle;
          valid_d = 1'b0;
          pc_d    = '0;
          ch_d    = '0;
        end else if (overrun) begin
          state_d = StFault;
          cause_d = 2'b01;
          valid_d = 1'b0;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (core_stop) begin
          done_d  = 1'b1;
          state_d = StIdle;
          valid_d = 1'b0;
          pc_d    = '0;
          ch_d    = '0;
        end else if (can_issue) begin
          if (ch_first) begin
            ldc_d = is_ldc;
            if (is_ldc) begin
              ldc_instr_d = instr_lo;
              load_data_d = instr_hi;
            end
          end
          if (is_efi) begin
            efi_start_d = 1'b1;
            state_d     = StEfiWait;
`ifdef FCORE_SEQUENCER_EFI_TIMEOUT_EN
            efi_cnt_d   = '0;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = beat_instr;
            dest_d  = ch_q;
            user_d  = pc_q;
            advance = 1'b1;
            adv_ldc = ldc_now;
          end
        end
      end

      StEfiWait: begin
        if (core_stop) begin
          done_d  = 1'b1;
          state_d = StIdle;
          valid_d = 1'b0;
          pc_d    = '0;
          ch_d    = '0;
        end else if (efi_timeout_hit) begin
          state_d = StFault;
          cause_d = 2'b10;
          valid_d = 1'b0;
        end else if (efi_done) begin
          advance = 1'b1;
          adv_ldc = ldc_q;
        end else begin
`ifdef FCORE_SEQUENCER_EFI_TIMEOUT_EN
          efi_cnt_d = efi_cnt_q + 16'd1;
`endif
        end
      end

      StFault: begin
        valid_d = 1'b0;
        if (fault_clear) begin
          state_d = StIdle;
          cause_d = 2'b00;
          pc_d    = '0;
          ch_d    = '0;
        end
      end

      default: state_d = StIdle;
    endcase

    // Shared channel advance: wrap moves to the next instruction (LDC skips its constant word).
    if (advance) begin
      if (ch_last) begin
        ch_d    = '0;
        pc_d    = pc_q + (adv_ldc ? PC_WIDTH'(2) : PC_WIDTH'(1));
        state_d = StFetch;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ch_q        <= '0;
      load_data_q <= '0;
      ldc_q       <= 1'b0;
      ldc_instr_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      dest_q      <= '0;
      user_q      <= '0;
      efi_start_q <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ch_q        <= ch_d;
      load_data_q <= load_data_d;
      ldc_q       <= ldc_d;
      ldc_instr_q <= ldc_instr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      dest_q      <= dest_d;
      user_q      <= user_d;
      efi_start_q <= efi_start_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
    end
  end

  assign program_counter          = pc_q;
  assign load_data                = load_data_q;
  assign efi_start                = efi_start_q;
  assign decoder_enable           = (state_q == StFetch) || (state_q == StRun) ||
                                    (state_q == StEfiWait);
  assign dma_enable               = (state_q == StIdle);
  assign done                     = done_q;
  assign fault                    = (state_q == StFault);
  assign fault_cause              = cause_q;
  assign instruction_stream_data  = data_q;
  assign instruction_stream_dest  = dest_q;
  assign instruction_stream_user  = user_q;
  assign instruction_stream_valid = valid_q;

endmodule
